sd_spi_master: RTL



---
 rtl/sd_spi_master_pkg.sv | 31 +++
 rtl/sd_spi_master_if.sv | 22 ++
 rtl/sd_spi_tick.sv | 40 ++++
 rtl/sd_spi_master.sv | 100 ++++++++++
 4 files changed

// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: speed codes, FSM states and
// the half-period lookup used by the bit-clock generator.
package sd_spi_master_pkg;

    localparam logic [1:0] SPD_DIV2 = 2'd0;
    localparam logic [1:0] SPD_DIV4 = 2'd1;
    localparam logic [1:0] SPD_DIV8 = 2'd2;
    localparam logic [1:0] SPD_SLOW = 2'd3;

    localparam int unsigned SLOW_DIV_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

    // Number of fclk cycles each sck phase lasts for a given speed code.
    function automatic int unsigned half_period(input logic [1:0] spd,
                                                input int unsigned slow_div);
        int unsigned h;
        case (spd)
            SPD_DIV2: h = 1;
            SPD_DIV4: h = 2;
            SPD_DIV8: h = 4;
            default:  h = slow_div / 2;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sd_spi_master_if.sv
// Host-side handshake between the Z80 port decoder and the SD SPI master.
// The port block uses the master modport; the shifter uses the slave modport.
interface sd_spi_master_if;

    logic       start;
    logic [1:0] speed;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;

    modport master (
        output start, speed, din,
        input  dout, busy, done
    );

    modport slave (
        input  start, speed, din,
        output dout, busy, done
    );

endinterface

// File: rtl/sd_spi_tick.sv
// Half-period timer: latches the speed code on load and, while enabled,
// emits a one-cycle tick every H fclk cycles.
module sd_spi_tick
    import sd_spi_master_pkg::*;
#(
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEFAULT
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] speed,
    input  logic       en,
    output logic       tick
);

    // Wide enough for SLOW_DIV/2-1 and for the fixed /8 reload value of 3.
    localparam int unsigned CW = ($clog2(SLOW_DIV / 2) < 2) ? 2 : $clog2(SLOW_DIV / 2);

    logic [CW-1:0] reload_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            reload_q <= CW'(half_period(speed, SLOW_DIV) - 1);
            cnt_q    <= CW'(half_period(speed, SLOW_DIV) - 1);
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_q <= reload_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD card: shifts din out MSB-first on sdo
// while shifting sdi in, then presents the received byte on dout with a done pulse.
module sd_spi_master
    import sd_spi_master_pkg::*;
#(
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEFAULT
) (
    input  logic               fclk,
    input  logic               rst_n,
    sd_spi_master_if.slave     host,
    output logic               sck,
    output logic               sdo,
    input  logic               sdi
);

    spi_state_e state_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [2:0] bit_q;
    logic [7:0] dout_q;
    logic       busy_q;
    logic       done_q;
    logic       sck_q;
    logic       sdo_q;
    logic       accept;
    logic       tick;

    // A start is only honoured when no transfer is running; the done cycle counts as idle.
    assign accept = host.start && !busy_q;

    sd_spi_tick #(
        .SLOW_DIV (SLOW_DIV)
    ) u_tick (
        .fclk  (fclk),
        .rst_n (rst_n),
        .load  (accept),
        .speed (host.speed),
        .en    (busy_q),
        .tick  (tick)
    );

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            dout_q  <= 8'hFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_q    <= host.din;
                        sdo_q   <= host.din[7];
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], sdi};
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sck_q <= 1'b0;
                        bit_q <= bit_q + 3'd1;
                        if (bit_q != 3'd7) begin
                            tx_q    <= {tx_q[6:0], 1'b0};
                            sdo_q   <= tx_q[6];
                            state_q <= LOW;
                        end else begin
                            // sdo keeps the LSB until the next accepted start.
                            dout_q  <= rx_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sck       = sck_q;
    assign sdo       = sdo_q;
    assign host.dout = dout_q;
    assign host.busy = busy_q;
    assign host.done = done_q;

endmodule
